// File: rtl/a0_change_logger.sv
// Watches the register-file a0 output and streams every new value through a small
// first-word-fall-through FIFO, counting changes that arrive while the FIFO is full.
module a0_change_logger #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n_i,
  input  logic [DATA_WIDTH-1:0]    a0_i,
  input  logic                     en_i,
  input  logic                     clr_i,
  input  logic                     ready_i,
  output logic                     valid_o,
  output logic [DATA_WIDTH-1:0]    data_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o,
  output logic [CNT_WIDTH-1:0]     drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]          PTR_ONE = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]           r_wptr;
  logic [AW:0]           r_rptr;
  logic [DATA_WIDTH-1:0] r_last;
  logic                  r_overflow;
  logic [CNT_WIDTH-1:0]  r_drop_cnt;

  logic w_empty;
  logic w_full;
  logic w_chg;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // Extra pointer MSB tells a full FIFO apart from an empty one.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_chg   = en_i && (a0_i != r_last);
  assign w_pop   = !w_empty && ready_i;
  assign w_push  = w_chg && (!w_full || w_pop);
  assign w_drop  = w_chg && w_full && !w_pop;

  assign valid_o    = !w_empty;
  assign data_o     = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
  assign level_o    = r_wptr - r_rptr;
  assign overflow_o = r_overflow;
  assign drop_cnt_o = r_drop_cnt;

  // NOTE: sequential state uses non-blocking (<=) so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_last     <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (en_i) begin
        r_last <= a0_i;
      end
      if (clr_i) begin
        r_wptr     <= '0;
        r_rptr     <= '0;
        r_overflow <= 1'b0;
        r_drop_cnt <= '0;
      end else begin
        if (w_push) begin
          r_wptr <= r_wptr + PTR_ONE;
        end
        if (w_pop) begin
          r_rptr <= r_rptr + PTR_ONE;
        end
        if (w_drop) begin
          r_overflow <= 1'b1;
          if (r_drop_cnt != '1) begin
            r_drop_cnt <= r_drop_cnt + CNT_ONE;
          end
        end
      end
    end
  end

  // NOTE: the storage array has no reset; stale entries are never observable
  // because data_o is forced to zero whenever the pointers say the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push && !clr_i) begin
      r_mem[r_wptr[AW-1:0]] <= a0_i;
    end
  end

endmodule

// File: tb/tb_a0_change_logger.sv
// Directed bench for a0_change_logger: stimulus queues the values it expects to
// see on the stream, and an independent monitor checks each handshake in order.
module tb_a0_change_logger;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 2;

  logic                    clk = 1'b0;
  logic                    rst_n_i;
  logic [DW-1:0]           a0_i;
  logic                    en_i;
  logic                    clr_i;
  logic                    ready_i;
  logic                    valid_o;
  logic [DW-1:0]           data_o;
  logic [$clog2(DEPTH):0]  level_o;
  logic                    overflow_o;
  logic [CW-1:0]           drop_cnt_o;

  int n_cmp = 0;
  int n_err = 0;
  int n_hs  = 0;
  logic [DW-1:0] exp_q[$];

  a0_change_logger #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst_n_i    (rst_n_i),
    .a0_i       (a0_i),
    .en_i       (en_i),
    .clr_i      (clr_i),
    .ready_i    (ready_i),
    .valid_o    (valid_o),
    .data_o     (data_o),
    .level_o    (level_o),
    .overflow_o (overflow_o),
    .drop_cnt_o (drop_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted beat must match the oldest expected value.
  always @(negedge clk) begin
    if (rst_n_i && valid_o && ready_i) begin
      n_hs++;
      if (exp_q.size() == 0) begin
        check("unexpected_beat", data_o, 32'hDEAD_BEEF);
      end else begin
        check("stream_data", data_o, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst_n_i = 1'b0;
    a0_i    = '0;
    en_i    = 1'b1;
    clr_i   = 1'b0;
    ready_i = 1'b0;

    // Reset state
    #3;
    check("rst_valid", valid_o, 0);
    check("rst_data", data_o, 0);
    check("rst_level", level_o, 0);
    check("rst_overflow", overflow_o, 0);
    check("rst_drop", drop_cnt_o, 0);
    #19 rst_n_i = 1'b1;

    // 1: a0 idle at zero never logs
    ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
      check("idle_valid", valid_o, 0);
      check("idle_level", level_o, 0);
    end

    // 2: 0 -> 5 -> 5 -> 9, one-cycle latency
    tick();
    a0_i = 32'd5;
    exp_q.push_back(32'd5);
    @(negedge clk);
    check("lat_before_edge", valid_o, 0);
    tick();
    @(negedge clk);
    check("lat_after_edge", valid_o, 1);
    tick();
    a0_i = 32'd9;
    exp_q.push_back(32'd9);
    repeat (4) tick();
    @(negedge clk);
    check("t2_drained", level_o, 0);

    // 3: fill with ready low, two changes dropped
    ready_i = 1'b0;
    tick();
    for (int v = 1; v <= 6; v++) begin
      a0_i = DW'(v);
      if (v <= 4) exp_q.push_back(DW'(v));
      tick();
    end
    @(negedge clk);
    check("t3_level", level_o, 4);
    check("t3_overflow", overflow_o, 1);
    check("t3_drop", drop_cnt_o, 2);
    check("t3_head", data_o, 1);

    // 4: full FIFO, pop and change on the same cycle
    tick();
    ready_i = 1'b1;
    a0_i    = 32'd7;
    exp_q.push_back(32'd7);
    tick();
    @(negedge clk);
    check("t4_level_held", level_o, 4);
    check("t4_no_drop", drop_cnt_o, 2);
    for (int i = 0; i < 20 && level_o != 0; i++) tick();
    @(negedge clk);
    check("t4_drained", level_o, 0);

    // 5: saturating drop counter, then flush
    tick();
    ready_i = 1'b0;
    for (int v = 10; v <= 18; v++) begin
      a0_i = DW'(v);
      if (v <= 13) exp_q.push_back(DW'(v));
      tick();
    end
    @(negedge clk);
    check("t5_level", level_o, 4);
    check("t5_overflow", overflow_o, 1);
    check("t5_drop_sat", drop_cnt_o, 3);
    tick();
    clr_i = 1'b1;
    a0_i  = 32'd19;
    tick();
    clr_i = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("t5_clr_level", level_o, 0);
    check("t5_clr_overflow", overflow_o, 0);
    check("t5_clr_drop", drop_cnt_o, 0);
    check("t5_clr_valid", valid_o, 0);
    ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      check("t5_no_relog", valid_o, 0);
    end

    // 6: asynchronous reset with three entries queued
    tick();
    ready_i = 1'b0;
    for (int v = 20; v <= 22; v++) begin
      a0_i = DW'(v);
      exp_q.push_back(DW'(v));
      tick();
    end
    @(negedge clk);
    check("t6_level_pre", level_o, 3);
    #2;
    rst_n_i = 1'b0;
    #1;
    check("t6_rst_valid", valid_o, 0);
    check("t6_rst_level", level_o, 0);
    check("t6_rst_data", data_o, 0);
    exp_q.delete();
    a0_i = '0;
    @(negedge clk);
    rst_n_i = 1'b1;
    tick();
    ready_i = 1'b1;
    a0_i    = 32'hA;
    exp_q.push_back(32'hA);
    repeat (5) tick();
    @(negedge clk);
    check("t6_final_level", level_o, 0);

    // End-of-run bookkeeping
    check("leftover_expected", DW'(exp_q.size()), 0);
    check("handshake_count", DW'(n_hs), 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
